// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bus: fetch requester, data requester and the memory port.
// Handshake: a requester raises *_req with stable address/data and holds it until its
// *_ready pulses for one cycle; *_err, when set, pulses in the same cycle as *_ready.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ready, if_err, d_rdata, d_ready, d_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ready, if_err, d_rdata, d_ready, d_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency memory port between instruction fetch and data access.
// Data wins contention unless the starve flag says fetch already lost once.
module mem_arbiter #(
  parameter int MEM_LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus,
  output logic [1:0]   dbg_state
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          starve_q, starve_d;
  logic          gsel_q, gsel_d;
  logic          we_q, we_d;
  logic [29:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          mem_req_q, mem_req_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          if_ready_q, if_ready_d;
  logic          if_err_q, if_err_d;
  logic          d_ready_q, d_ready_d;
  logic          d_err_q, d_err_d;

  logic        any_req;
  logic        grant_data;
  logic [31:0] g_addr;
  logic        g_mis;

  // gsel = 1 selects the data requester
  assign any_req    = bus.if_req | bus.d_req;
  assign grant_data = bus.d_req & (~bus.if_req | ~starve_q);
  assign g_addr     = grant_data ? bus.d_addr : bus.if_addr;
  assign g_mis      = |g_addr[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      starve_q   <= 1'b0;
      gsel_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_req_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ready_q <= 1'b0;
      if_err_q   <= 1'b0;
      d_ready_q  <= 1'b0;
      d_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      gsel_q     <= gsel_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_req_q  <= mem_req_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ready_q <= if_ready_d;
      if_err_q   <= if_err_d;
      d_ready_q  <= d_ready_d;
      d_err_q    <= d_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = g_mis ? S_DONE : S_BUSY;
      S_BUSY:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    gsel_d     = gsel_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_req_d  = mem_req_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ready_d = 1'b0;
    if_err_d   = 1'b0;
    d_ready_d  = 1'b0;
    d_err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gsel_d  = grant_data;
          addr_d  = g_addr[31:2];
          wdata_d = bus.d_wdata;
          we_d    = grant_data & bus.d_we;
          // data only beats a waiting fetch when starve is clear, and marks it
          if (!grant_data)     starve_d = 1'b0;
          else if (bus.if_req) starve_d = 1'b1;
          if (g_mis) begin
            d_ready_d  = grant_data;
            d_err_d    = grant_data;
            if_ready_d = ~grant_data;
            if_err_d   = ~grant_data;
          end else begin
            mem_req_d = 1'b1;
            cnt_d     = CW'(MEM_LATENCY - 1);
          end
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          mem_req_d = 1'b0;
          if (gsel_q) begin
            if (!we_q) d_rdata_d = bus.mem_rdata;
            d_ready_d = 1'b1;
          end else begin
            if_rdata_d = bus.mem_rdata;
            if_ready_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.if_err    = if_err_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.d_err     = d_err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level arbitration model fills
// expected queues, a memory responder and ready monitors pop and compare.
module tb_mem_arbiter;

  localparam int L = 2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state1;

  int cyc    = 0;
  int checks = 0;
  int passed = 0;

  logic [64:0] exp_if_q[$];
  logic [64:0] exp_d_q[$];
  logic [62:0] exp_mem_q[$];
  logic [31:0] tb_mem  [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] last_if = '0;
  logic [31:0] last_d  = '0;
  bit          starve_m = 1'b0;

  mem_arbiter_if bus();
  mem_arbiter_if bus1();

  mem_arbiter #(.MEM_LATENCY(L)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  mem_arbiter #(.MEM_LATENCY(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus1),
    .dbg_state (dbg_state1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] init_word(input logic [29:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] tb_rd(input logic [29:0] a);
    return tb_mem.exists(a) ? tb_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'h0040_0000 | (32'($urandom_range(0, 15)) << 2);
    if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  function automatic dreq_t rand_dreq();
    dreq_t r;
    r.we    = 1'($urandom_range(0, 1));
    r.addr  = rand_addr();
    r.wdata = $urandom();
    return r;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  task automatic serve_f(inout int t, input logic [31:0] a);
    if (a[1:0] != 2'b00) begin
      exp_if_q.push_back({32'(t + 1), 1'b1, last_if});
      t += 2;
    end else begin
      last_if = ref_rd(a[31:2]);
      exp_mem_q.push_back({a[31:2], 1'b0, 32'h0});
      exp_if_q.push_back({32'(t + L + 1), 1'b0, last_if});
      t += L + 2;
    end
  endtask

  task automatic serve_d(inout int t, input dreq_t r);
    if (r.addr[1:0] != 2'b00) begin
      exp_d_q.push_back({32'(t + 1), 1'b1, last_d});
      t += 2;
    end else begin
      if (r.we) begin
        ref_mem[r.addr[31:2]] = r.wdata;
        exp_mem_q.push_back({r.addr[31:2], 1'b1, r.wdata});
      end else begin
        last_d = ref_rd(r.addr[31:2]);
        exp_mem_q.push_back({r.addr[31:2], 1'b0, 32'h0});
      end
      exp_d_q.push_back({32'(t + L + 1), 1'b0, last_d});
      t += L + 2;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_f();
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = bus.if_ready;
    end
    check("if_timeout", 96'(seen), 96'd1);
    bus.if_req = 1'b0;
  endtask

  task automatic wait_d(input bit d2, input dreq_t r2);
    for (int k = 0; k < (d2 ? 2 : 1); k++) begin
      bit seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
        @(negedge clk);
        seen = bus.d_ready;
      end
      check("d_timeout", 96'(seen), 96'd1);
      if (k == 0 && d2) begin
        bus.d_we    = r2.we;
        bus.d_addr  = r2.addr;
        bus.d_wdata = r2.wdata;
      end
    end
    bus.d_req = 1'b0;
  endtask

  // One arbitration episode; d2 re-requests data as soon as the first data access completes.
  task automatic do_round(input bit df, input logic [31:0] fa, input bit dd,
                          input dreq_t r1, input bit d2, input dreq_t r2);
    int t;
    bit f_pend, d_pend, pick_d;
    int d_idx;
    @(posedge clk);
    #1;
    t = cyc;
    bus.if_req  = df;
    bus.if_addr = fa;
    bus.d_req   = dd;
    bus.d_we    = r1.we;
    bus.d_addr  = r1.addr;
    bus.d_wdata = r1.wdata;
    f_pend = df;
    d_pend = dd;
    d_idx  = 0;
    while (f_pend || d_pend) begin
      pick_d = d_pend && (!f_pend || !starve_m);
      if (pick_d) begin
        if (f_pend) starve_m = 1'b1;
        serve_d(t, (d_idx == 0) ? r1 : r2);
        d_idx++;
        d_pend = (d_idx == 1) && d2;
      end else begin
        starve_m = 1'b0;
        serve_f(t, fa);
        f_pend = 1'b0;
      end
    end
    fork
      begin if (df) wait_f(); end
      begin if (dd) wait_d(d2, r2); end
    join
  endtask

  // ---------------- memory responder ----------------
  int          run = 0;
  logic [62:0] run_sig;
  logic [62:0] cur_sig;
  bit          run_stable;

  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
      bus.mem_rdata = '0;
    end else if (bus.mem_req) begin
      cur_sig = {bus.mem_addr, bus.mem_we, bus.mem_we ? bus.mem_wdata : 32'h0};
      if (run == 0) begin
        if (exp_mem_q.size() == 0) begin
          checks++;
          $display("FAIL mem_unexpected: got access %0h expected none at cycle %0d", cur_sig, cyc);
        end else begin
          check("mem_access", 96'(cur_sig), 96'(exp_mem_q.pop_front()));
        end
        run_sig    = cur_sig;
        run_stable = 1'b1;
      end else if (cur_sig !== run_sig) begin
        run_stable = 1'b0;
      end
      run++;
      if (run == L) begin
        bus.mem_rdata = tb_rd(bus.mem_addr);
        if (bus.mem_we) tb_mem[bus.mem_addr] = bus.mem_wdata;
      end else begin
        bus.mem_rdata = $urandom();
      end
    end else begin
      if (run != 0) begin
        check("mem_req_len", 96'(run), 96'(L));
        check("mem_hold", 96'(run_stable), 96'd1);
      end
      run = 0;
      bus.mem_rdata = $urandom();
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.if_ready) begin
        if (exp_if_q.size() == 0) begin
          checks++;
          $display("FAIL if_ready_unexpected: got pulse expected none at cycle %0d", cyc);
        end else begin
          check("if_resp", {32'(cyc), bus.if_err, bus.if_rdata}, 96'(exp_if_q.pop_front()));
        end
      end
      if (bus.d_ready) begin
        if (exp_d_q.size() == 0) begin
          checks++;
          $display("FAIL d_ready_unexpected: got pulse expected none at cycle %0d", cyc);
        end else begin
          check("d_resp", {32'(cyc), bus.d_err, bus.d_rdata}, 96'(exp_d_q.pop_front()));
        end
      end
      if ((bus.if_err && !bus.if_ready) || (bus.d_err && !bus.d_ready)) begin
        checks++;
        $display("FAIL err_alone: got err without ready expected err only with ready at cycle %0d", cyc);
      end
    end
  end

  // ---------------- MEM_LATENCY=1 instance monitor ----------------
  int run1    = 0;
  int last1   = -1;
  int pulses1 = 0;

  always @(negedge clk) begin
    bus1.mem_rdata = init_word(bus1.mem_addr);
    if (rst_n) begin
      if (bus1.mem_req) begin
        run1++;
      end else begin
        if (run1 != 0) check("l1_mem_req_len", 96'(run1), 96'd1);
        run1 = 0;
      end
      if (bus1.if_ready) begin
        if (last1 >= 0) check("l1_period", 96'(cyc - last1), 96'd3);
        check("l1_rdata", {bus1.if_err, bus1.if_rdata}, {1'b0, init_word(30'h0010_0004)});
        last1 = cyc;
        pulses1++;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    dreq_t none;
    dreq_t r1;
    dreq_t r2;
    int    t;
    int    kind;
    none = '0;
    bus.if_req = 1'b0;  bus.if_addr = '0;  bus.d_req = 1'b0;
    bus.d_we = 1'b0;    bus.d_addr = '0;   bus.d_wdata = '0;
    bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.d_req = 1'b0;
    bus1.d_we = 1'b0;   bus1.d_addr = '0;  bus1.d_wdata = '0;

    #12;
    check("rst_mem", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 96'd0);
    check("rst_if", {bus.if_rdata, bus.if_ready, bus.if_err}, 96'd0);
    check("rst_d", {bus.d_rdata, bus.d_ready, bus.d_err}, 96'd0);
    check("rst_state", 96'(dbg_state), 96'd0);
    check("rst_l1", {bus1.mem_req, bus1.if_ready, bus1.d_ready, bus1.if_rdata}, 96'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // fetch alone
    do_round(1'b1, 32'h0040_0004, 1'b0, none, 1'b0, none);
    // contention: data then fetch; then data/fetch/data with a starved fetch winning
    do_round(1'b1, 32'h0040_0008, 1'b1, '{we: 1'b0, addr: 32'h0040_000C, wdata: 32'h0}, 1'b0, none);
    do_round(1'b1, 32'h0040_0010, 1'b1, '{we: 1'b0, addr: 32'h0040_0014, wdata: 32'h0},
             1'b1, '{we: 1'b0, addr: 32'h0040_0018, wdata: 32'h0});
    do_round(1'b1, 32'h0040_001C, 1'b1, '{we: 1'b0, addr: 32'h0040_0020, wdata: 32'h0}, 1'b0, none);
    // store, then load it back, then misaligned load
    do_round(1'b0, 32'h0, 1'b1, '{we: 1'b1, addr: 32'h1000_0010, wdata: 32'hDEAD_BEEF}, 1'b0, none);
    do_round(1'b0, 32'h0, 1'b1, '{we: 1'b0, addr: 32'h1000_0010, wdata: 32'h0}, 1'b0, none);
    do_round(1'b0, 32'h0, 1'b1, '{we: 1'b0, addr: 32'h1000_0006, wdata: 32'h0}, 1'b0, none);
    do_round(1'b1, 32'h0040_0002, 1'b0, none, 1'b0, none);

    // reset in the middle of a fetch
    @(posedge clk);
    #1;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0040_0008;
    bus.d_req   = 1'b0;
    exp_mem_q.push_back({30'h0010_0002, 1'b0, 32'h0});
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_mem_req", 96'(bus.mem_req), 96'd0);
    check("midrst_outs", {bus.if_ready, bus.if_rdata, bus.d_rdata, bus.mem_addr}, 96'd0);
    check("midrst_state", 96'(dbg_state), 96'd0);
    starve_m = 1'b0;
    last_if  = '0;
    last_d   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    t = cyc;
    last_if = ref_rd(30'h0010_0002);
    exp_mem_q.push_back({30'h0010_0002, 1'b0, 32'h0});
    exp_if_q.push_back({32'(t + 3), 1'b0, last_if});
    wait_f();

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      kind = $urandom_range(0, 3);
      r1 = rand_dreq();
      r2 = rand_dreq();
      case (kind)
        0:       do_round(1'b1, rand_addr(), 1'b0, none, 1'b0, none);
        1:       do_round(1'b0, 32'h0, 1'b1, r1, 1'b0, none);
        2:       do_round(1'b1, rand_addr(), 1'b1, r1, 1'b0, none);
        default: do_round(1'b1, rand_addr(), 1'b1, r1, 1'b1, r2);
      endcase
    end

    // continuous fetch stream on the single-cycle-latency build
    @(posedge clk);
    #1;
    bus1.if_addr = 32'h0040_0010;
    bus1.if_req  = 1'b1;
    repeat (20) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus1.if_ready) break;
    end
    bus1.if_req = 1'b0;
    repeat (4) @(posedge clk);
    check("l1_pulses", 96'(pulses1 >= 6), 96'd1);

    repeat (4) @(posedge clk);
    check("if_q_empty", 96'(exp_if_q.size()), 96'd0);
    check("d_q_empty", 96'(exp_d_q.size()), 96'd0);
    check("mem_q_empty", 96'(exp_mem_q.size()), 96'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
